// File: rtl/resilient_pipe_ctrl_pkg.sv
// Shared types for the resilient pipeline controller: stage states and
// dual-rail error codes as presented on {Err1, Err0}.
package resilient_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        EVAL    = 2'd1,
        RECOVER = 2'd2,
        FULL    = 2'd3
    } stage_st_e;

    // {rail "error", rail "no error"}
    localparam logic [1:0] DR_NULL = 2'b00;  // detector not yet resolved
    localparam logic [1:0] DR_OK   = 2'b01;
    localparam logic [1:0] DR_ERR  = 2'b10;
    localparam logic [1:0] DR_ILL  = 2'b11;  // both rails high: illegal

endpackage

// File: rtl/resilient_pipe_ctrl_if.sv
// Handshake and datapath-control bundle between the controller (master)
// and its environment: producer, consumer, stage latches and detectors.
interface resilient_pipe_ctrl_if #(
    parameter int STAGES = 3
);
    logic              Lreq;
    logic              Lack;
    logic              Rreq;
    logic              Rack;
    logic [STAGES-1:0] Err1;
    logic [STAGES-1:0] Err0;
    logic [STAGES-1:0] cap_en;
    logic [STAGES-1:0] sample;

    modport master (
        input  Lreq, Rack, Err1, Err0,
        output Lack, Rreq, cap_en, sample
    );

    modport slave (
        output Lreq, Rack, Err1, Err0,
        input  Lack, Rreq, cap_en, sample
    );
endinterface

// File: rtl/resilient_pipe_ctrl_stage_fsm.sv
// One pipeline stage: EMPTY -> EVAL -> (RECOVER ->) FULL. Owns the
// dual-rail resolution timeout counter. rec/perr are next-edge pulses.
module resilient_stage_fsm
    import resilient_pkg::*;
#(
    parameter int ERR_TIMEOUT = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      cap_in,   // new token captured into this stage
    input  logic      leave,    // downstream takes this stage's token
    input  logic      err1,
    input  logic      err0,
    output stage_st_e st,
    output logic      sample,
    output logic      rec,      // entering RECOVER on this edge
    output logic      perr      // protocol violation on this edge
);
    localparam int TW = $clog2(ERR_TIMEOUT + 1);

    stage_st_e      st_nxt;
    logic [TW-1:0]  tcnt, tcnt_nxt;

    assign sample = (st == EVAL);

    // next-state decode; Err rails only matter while evaluating
    always_comb begin
        st_nxt   = st;
        tcnt_nxt = tcnt;
        rec      = 1'b0;
        perr     = 1'b0;
        case (st)
            EMPTY: begin
                if (cap_in) begin
                    st_nxt   = EVAL;
                    tcnt_nxt = '0;
                end
            end
            EVAL: begin
                case ({err1, err0})
                    DR_OK:  st_nxt = FULL;
                    DR_ERR: begin
                        st_nxt = RECOVER;
                        rec    = 1'b1;
                    end
                    DR_ILL: begin
                        st_nxt = RECOVER;
                        rec    = 1'b1;
                        perr   = 1'b1;
                    end
                    default: begin
                        // unresolved: give up after ERR_TIMEOUT cycles and re-capture
                        if (tcnt == TW'(ERR_TIMEOUT - 1)) begin
                            st_nxt   = RECOVER;
                            rec      = 1'b1;
                            perr     = 1'b1;
                            tcnt_nxt = '0;
                        end else begin
                            tcnt_nxt = tcnt + TW'(1);
                        end
                    end
                endcase
            end
            RECOVER: st_nxt = FULL;
            FULL: begin
                if (leave) begin
                    if (cap_in) begin
                        st_nxt   = EVAL;
                        tcnt_nxt = '0;
                    end else begin
                        st_nxt = EMPTY;
                    end
                end
            end
            default: st_nxt = EMPTY;
        endcase
    end

    // state and timeout counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= EMPTY;
            tcnt <= '0;
        end else begin
            st   <= st_nxt;
            tcnt <= tcnt_nxt;
        end
    end

endmodule

// File: rtl/resilient_pipe_ctrl.sv
// Controller for an N-stage error-detecting datapath. Ripples accept from
// the output side, issues capture strobes, counts recovered errors and
// latches protocol violations.
module resilient_pipe_ctrl
    import resilient_pkg::*;
#(
    parameter int STAGES      = 3,
    parameter int ERR_TIMEOUT = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    resilient_pipe_ctrl_if.master bus,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 protocol_err
);
    localparam int PW = $clog2(STAGES + 1);
    localparam int SW = CNT_W + PW;
    localparam logic [SW-1:0] CMAX = {{PW{1'b0}}, {CNT_W{1'b1}}};

    stage_st_e         st [STAGES];
    logic [STAGES-1:0] accept, leave, cap_in, cap_en, smp, rec, perr;
    logic              ripple;
    logic [PW-1:0]     pc;
    logic [SW-1:0]     sum;

    // accept/leave ripple from the consumer back to the producer
    always_comb begin
        ripple = bus.Rack;
        accept = '0;
        leave  = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            leave[i]  = ripple;
            accept[i] = (st[i] == EMPTY) | ((st[i] == FULL) & ripple);
            ripple    = accept[i];
        end
    end

    // fresh-token captures: from upstream for stage 0, from the previous stage otherwise
    always_comb begin
        cap_in    = '0;
        cap_in[0] = bus.Lreq & accept[0] & ~rst;
        for (int i = 1; i < STAGES; i++)
            cap_in[i] = (st[i-1] == FULL) & accept[i];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        resilient_stage_fsm #(
            .ERR_TIMEOUT(ERR_TIMEOUT)
        ) u_fsm (
            .clk    (clk),
            .rst    (rst),
            .cap_in (cap_in[i]),
            .leave  (leave[i]),
            .err1   (bus.Err1[i]),
            .err0   (bus.Err0[i]),
            .st     (st[i]),
            .sample (smp[i]),
            .rec    (rec[i]),
            .perr   (perr[i])
        );
        // RECOVER re-captures the corrected data for one cycle
        assign cap_en[i] = cap_in[i] | (st[i] == RECOVER);
    end

    assign bus.Lack   = accept[0] & ~rst;
    assign bus.Rreq   = (st[STAGES-1] == FULL);
    assign bus.cap_en = cap_en;
    assign bus.sample = smp;

    // number of stages entering RECOVER this edge, added to the count
    always_comb begin
        pc = '0;
        for (int i = 0; i < STAGES; i++)
            pc = pc + PW'(rec[i]);
        sum = SW'(err_cnt) + SW'(pc);
    end

    // saturating error counter and sticky protocol flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt      <= '0;
            protocol_err <= 1'b0;
        end else begin
            err_cnt      <= (sum > CMAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
            protocol_err <= protocol_err | (|perr);
        end
    end

endmodule

// File: tb/tb_resilient_pipe_ctrl.sv
// Directed bench for resilient_pipe_ctrl. Cycle c starts 1 time unit after
// a rising edge; inputs are driven then, outputs sampled 2 units later.
module tb_resilient_pipe_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    resilient_pipe_ctrl_if #(.STAGES(3)) ifa ();
    resilient_pipe_ctrl_if #(.STAGES(3)) ifb ();

    logic [7:0] cnt_a;
    logic       perr_a;
    logic [1:0] cnt_b;
    logic       perr_b;

    resilient_pipe_ctrl #(.STAGES(3), .ERR_TIMEOUT(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .bus(ifa.master), .err_cnt(cnt_a), .protocol_err(perr_a)
    );

    resilient_pipe_ctrl #(.STAGES(3), .ERR_TIMEOUT(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .bus(ifb.master), .err_cnt(cnt_b), .protocol_err(perr_b)
    );

    int checks = 0;
    int errors = 0;

    logic [2:0] capl [16];
    logic [2:0] smpl [16];
    logic       rql  [16];
    logic       lackl[16];
    logic       perrl[16];
    logic [7:0] cntl [16];

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.Lreq = 0; ifa.Rack = 0; ifa.Err1 = 3'b000; ifa.Err0 = 3'b111;
        ifb.Lreq = 0; ifb.Rack = 0; ifb.Err1 = 3'b000; ifb.Err0 = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // runs cycles 0..n-1 on ifa, Lreq high in cycle 0 only, logging outputs
    task automatic run_one_token(input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) next_cyc();
            ifa.Lreq = (c == 0);
            #2;
            capl[c] = ifa.cap_en; smpl[c] = ifa.sample; rql[c] = ifa.Rreq;
            perrl[c] = perr_a; cntl[c] = cnt_a; lackl[c] = ifa.Lack;
        end
    endtask

    task automatic test_reset();
        ifa.Lreq = 1; ifa.Rack = 1; ifa.Err1 = 3'b111; ifa.Err0 = 3'b000;
        ifb.Lreq = 0; ifb.Rack = 0; ifb.Err1 = 3'b000; ifb.Err0 = 3'b111;
        #3;
        checks++; if (ifa.Lack !== 1'b0) begin errors++; $display("FAIL rst_lack got %0b want 0", ifa.Lack); end
        checks++; if (ifa.Rreq !== 1'b0) begin errors++; $display("FAIL rst_rreq got %0b want 0", ifa.Rreq); end
        checks++; if (ifa.cap_en !== 3'b000) begin errors++; $display("FAIL rst_cap got %b want 000", ifa.cap_en); end
        checks++; if (ifa.sample !== 3'b000) begin errors++; $display("FAIL rst_sample got %b want 000", ifa.sample); end
        checks++; if (cnt_a !== 8'd0 || perr_a !== 1'b0) begin errors++; $display("FAIL rst_cnt_perr got %0d/%0b want 0/0", cnt_a, perr_a); end
        do_reset();
        #2;
        checks++; if (ifa.Lack !== 1'b1) begin errors++; $display("FAIL rst_release_lack got %0b want 1", ifa.Lack); end
    endtask

    task automatic test_single_ok();
        logic [2:0] exp_cap;
        int first;
        do_reset();
        ifa.Rack = 1;
        run_one_token(10);
        for (int c = 0; c < 10; c++) begin
            exp_cap = (c == 0) ? 3'b001 : (c == 2) ? 3'b010 : (c == 4) ? 3'b100 : 3'b000;
            checks++; if (capl[c] !== exp_cap) begin errors++; $display("FAIL ok_cap c%0d got %b want %b", c, capl[c], exp_cap); end
        end
        first = -1;
        for (int c = 9; c >= 0; c--) if (rql[c] === 1'b1) first = c;
        checks++; if (first != 6) begin errors++; $display("FAIL ok_rreq_cycle got %0d want 6", first); end
        checks++; if (cntl[9] !== 8'd0) begin errors++; $display("FAIL ok_errcnt got %0d want 0", cntl[9]); end
    endtask

    task automatic test_stage_err();
        logic [2:0] exp_cap;
        int first;
        do_reset();
        ifa.Rack = 0; ifa.Err1 = 3'b010; ifa.Err0 = 3'b101;
        run_one_token(10);
        for (int c = 0; c < 10; c++) begin
            exp_cap = (c == 0) ? 3'b001 : (c == 2 || c == 4) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            checks++; if (capl[c] !== exp_cap) begin errors++; $display("FAIL err_cap c%0d got %b want %b", c, capl[c], exp_cap); end
        end
        checks++; if (smpl[3] !== 3'b010 || smpl[4] !== 3'b000) begin errors++; $display("FAIL err_sample got %b,%b want 010,000", smpl[3], smpl[4]); end
        first = -1;
        for (int c = 9; c >= 0; c--) if (rql[c] === 1'b1) first = c;
        checks++; if (first != 7) begin errors++; $display("FAIL err_rreq_cycle got %0d want 7", first); end
        checks++; if (cntl[4] !== 8'd1 || cntl[9] !== 8'd1) begin errors++; $display("FAIL err_errcnt got %0d,%0d want 1,1", cntl[4], cntl[9]); end
    endtask

    task automatic test_fill();
        int acc;
        int late_lack;
        do_reset();
        ifa.Rack = 0; ifa.Lreq = 1;
        acc = 0; late_lack = 0;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) next_cyc();
            #2;
            if (ifa.Lreq && ifa.Lack) acc++;
            if (c >= 5 && ifa.Lack !== 1'b0) late_lack++;
        end
        checks++; if (acc != 3) begin errors++; $display("FAIL fill_accepts got %0d want 3", acc); end
        checks++; if (late_lack != 0) begin errors++; $display("FAIL fill_lack_stuck got %0d cycles high want 0", late_lack); end
        checks++; if (ifa.Rreq !== 1'b1) begin errors++; $display("FAIL fill_rreq got %0b want 1", ifa.Rreq); end
        next_cyc();
        ifa.Rack = 1;
        #2;
        checks++; if (ifa.Lack !== 1'b1) begin errors++; $display("FAIL release_lack got %0b want 1", ifa.Lack); end
        checks++; if (ifa.cap_en !== 3'b111) begin errors++; $display("FAIL release_cap got %b want 111", ifa.cap_en); end
        next_cyc();
        ifa.Rack = 0; ifa.Lreq = 0;
        #2;
        checks++; if (ifa.Rreq !== 1'b0) begin errors++; $display("FAIL release_rreq_drop got %0b want 0", ifa.Rreq); end
        checks++; if (ifa.sample !== 3'b111) begin errors++; $display("FAIL release_sample got %b want 111", ifa.sample); end
    endtask

    task automatic test_timeout();
        do_reset();
        ifa.Rack = 1; ifa.Err1 = 3'b000; ifa.Err0 = 3'b000;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) next_cyc();
            ifa.Lreq = (c == 0);
            if (c == 5) ifa.Err0 = 3'b111;
            #2;
            capl[c] = ifa.cap_en; smpl[c] = ifa.sample; rql[c] = ifa.Rreq;
            perrl[c] = perr_a; cntl[c] = cnt_a;
        end
        checks++; if (smpl[4] !== 3'b001 || perrl[4] !== 1'b0) begin errors++; $display("FAIL to_eval c4 sample %b perr %0b want 001/0", smpl[4], perrl[4]); end
        checks++; if (perrl[5] !== 1'b1) begin errors++; $display("FAIL to_perr got %0b want 1", perrl[5]); end
        checks++; if (capl[5] !== 3'b001 || smpl[5] !== 3'b000) begin errors++; $display("FAIL to_recover cap %b sample %b want 001/000", capl[5], smpl[5]); end
        checks++; if (cntl[5] !== 8'd1) begin errors++; $display("FAIL to_errcnt got %0d want 1", cntl[5]); end
        checks++; if (rql[9] !== 1'b0 || rql[10] !== 1'b1) begin errors++; $display("FAIL to_rreq c9/c10 got %0b%0b want 01", rql[9], rql[10]); end
        checks++; if (perrl[11] !== 1'b1 || cntl[11] !== 8'd1) begin errors++; $display("FAIL to_sticky perr %0b cnt %0d want 1/1", perrl[11], cntl[11]); end
    endtask

    // leaves the pipeline busy at cycle 5 and then resets asynchronously
    task automatic test_illegal_and_async_reset();
        int stale;
        do_reset();
        #2;
        checks++; if (perr_a !== 1'b0) begin errors++; $display("FAIL ill_perr_cleared got %0b want 0", perr_a); end
        ifa.Rack = 1; ifa.Err1 = 3'b001; ifa.Err0 = 3'b111; ifa.Lreq = 1;
        for (int c = 1; c < 6; c++) begin
            next_cyc();
            ifa.Lreq = (c >= 3);
            #2;
            capl[c] = ifa.cap_en; perrl[c] = perr_a; cntl[c] = cnt_a;
        end
        checks++; if (perrl[2] !== 1'b1 || cntl[2] !== 8'd1 || capl[2] !== 3'b001) begin errors++; $display("FAIL ill_recover perr %0b cnt %0d cap %b want 1/1/001", perrl[2], cntl[2], capl[2]); end
        checks++; if (capl[5] !== 3'b101 || cntl[5] !== 8'd2) begin errors++; $display("FAIL ill_busy cap %b cnt %0d want 101/2", capl[5], cntl[5]); end
        rst = 1'b1;
        #1;
        checks++; if (ifa.Lack !== 1'b0 || ifa.Rreq !== 1'b0) begin errors++; $display("FAIL arst_hs lack %0b rreq %0b want 0/0", ifa.Lack, ifa.Rreq); end
        checks++; if (ifa.cap_en !== 3'b000 || ifa.sample !== 3'b000) begin errors++; $display("FAIL arst_strobes cap %b sample %b want 000/000", ifa.cap_en, ifa.sample); end
        checks++; if (cnt_a !== 8'd0 || perr_a !== 1'b0) begin errors++; $display("FAIL arst_cnt cnt %0d perr %0b want 0/0", cnt_a, perr_a); end
        ifa.Lreq = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        checks++; if (ifa.Lack !== 1'b1) begin errors++; $display("FAIL arst_release_lack got %0b want 1", ifa.Lack); end
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            next_cyc();
            #2;
            if (ifa.Rreq !== 1'b0 || ifa.cap_en !== 3'b000) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL arst_stale got %0d active cycles want 0", stale); end
    endtask

    task automatic test_saturate();
        do_reset();
        ifb.Rack = 0; ifb.Lreq = 1;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cyc();
            #2;
        end
        checks++; if (ifb.Rreq !== 1'b1 || ifb.Lack !== 1'b0) begin errors++; $display("FAIL sat_fill rreq %0b lack %0b want 1/0", ifb.Rreq, ifb.Lack); end
        for (int b = 0; b < 2; b++) begin
            next_cyc();
            ifb.Lreq = 1; ifb.Rack = 1; ifb.Err1 = 3'b111; ifb.Err0 = 3'b000;
            #2;
            checks++; if (ifb.cap_en !== 3'b111) begin errors++; $display("FAIL sat_cap b%0d got %b want 111", b, ifb.cap_en); end
            next_cyc();
            ifb.Lreq = 0; ifb.Rack = 0;
            #2;
            checks++; if (ifb.sample !== 3'b111) begin errors++; $display("FAIL sat_sample b%0d got %b want 111", b, ifb.sample); end
            next_cyc();
            #2;
            checks++; if (cnt_b !== 2'd3) begin errors++; $display("FAIL sat_cnt b%0d got %0d want 3", b, cnt_b); end
            next_cyc();
            #2;
        end
        checks++; if (perr_b !== 1'b0) begin errors++; $display("FAIL sat_perr got %0b want 0", perr_b); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_ok();
        test_stage_err();
        test_fill();
        test_timeout();
        test_illegal_and_async_reset();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
